// File: rtl/cpu_pkg.sv
// Shared types for cpu_core: FSM states, decoded-instruction struct, opcodes,
// status bit positions and reset constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RESET_LO, ST_RESET_HI, ST_FETCH, ST_OPERAND_LO,
    ST_OPERAND_HI, ST_INDEX, ST_ACCESS
  } state_t;

  typedef enum logic [1:0] {K_NOP, K_LOAD, K_STORE} op_kind_t;
  typedef enum logic [1:0] {AM_IMM, AM_ZP, AM_ZPI, AM_ABS} addr_mode_t;
  typedef enum logic [1:0] {RG_A, RG_X, RG_Y} reg_sel_t;

  typedef struct packed {
    op_kind_t   kind;
    addr_mode_t mode;
    reg_sel_t   rsel;
  } decode_t;

  localparam logic [7:0] OPC_LDA_IMM = 8'hA9, OPC_LDA_ZP = 8'hA5, OPC_LDA_ZPX = 8'hB5, OPC_LDA_ABS = 8'hAD;
  localparam logic [7:0] OPC_LDX_IMM = 8'hA2, OPC_LDX_ZP = 8'hA6, OPC_LDX_ZPY = 8'hB6, OPC_LDX_ABS = 8'hAE;
  localparam logic [7:0] OPC_LDY_IMM = 8'hA0, OPC_LDY_ZP = 8'hA4, OPC_LDY_ZPX = 8'hB4, OPC_LDY_ABS = 8'hAC;
  localparam logic [7:0] OPC_STA_ZP  = 8'h85, OPC_STA_ZPX = 8'h95, OPC_STA_ABS = 8'h8D;
  localparam logic [7:0] OPC_STX_ZP  = 8'h86, OPC_STX_ZPY = 8'h96, OPC_STX_ABS = 8'h8E;
  localparam logic [7:0] OPC_STY_ZP  = 8'h84, OPC_STY_ZPX = 8'h94, OPC_STY_ABS = 8'h8C;
  localparam logic [7:0] OPC_NOP     = 8'hEA;

  localparam int STATUS_ZERO     = 1;
  localparam int STATUS_NEGATIVE = 7;

  localparam logic [7:0] P_RESET  = 8'h34;
  localparam logic [7:0] SP_RESET = 8'hFD;

  // Undefined opcodes fall through to the NOP default.
  function automatic decode_t decode(input logic [7:0] op);
    decode_t d;
    d = '{K_NOP, AM_IMM, RG_A};
    case (op)
      OPC_LDA_IMM: d = '{K_LOAD, AM_IMM, RG_A};
      OPC_LDA_ZP:  d = '{K_LOAD, AM_ZP,  RG_A};
      OPC_LDA_ZPX: d = '{K_LOAD, AM_ZPI, RG_A};
      OPC_LDA_ABS: d = '{K_LOAD, AM_ABS, RG_A};
      OPC_LDX_IMM: d = '{K_LOAD, AM_IMM, RG_X};
      OPC_LDX_ZP:  d = '{K_LOAD, AM_ZP,  RG_X};
      OPC_LDX_ZPY: d = '{K_LOAD, AM_ZPI, RG_X};
      OPC_LDX_ABS: d = '{K_LOAD, AM_ABS, RG_X};
      OPC_LDY_IMM: d = '{K_LOAD, AM_IMM, RG_Y};
      OPC_LDY_ZP:  d = '{K_LOAD, AM_ZP,  RG_Y};
      OPC_LDY_ZPX: d = '{K_LOAD, AM_ZPI, RG_Y};
      OPC_LDY_ABS: d = '{K_LOAD, AM_ABS, RG_Y};
      OPC_STA_ZP:  d = '{K_STORE, AM_ZP,  RG_A};
      OPC_STA_ZPX: d = '{K_STORE, AM_ZPI, RG_A};
      OPC_STA_ABS: d = '{K_STORE, AM_ABS, RG_A};
      OPC_STX_ZP:  d = '{K_STORE, AM_ZP,  RG_X};
      OPC_STX_ZPY: d = '{K_STORE, AM_ZPI, RG_X};
      OPC_STX_ABS: d = '{K_STORE, AM_ABS, RG_X};
      OPC_STY_ZP:  d = '{K_STORE, AM_ZP,  RG_Y};
      OPC_STY_ZPX: d = '{K_STORE, AM_ZPI, RG_Y};
      OPC_STY_ABS: d = '{K_STORE, AM_ABS, RG_Y};
      default:     d = '{K_NOP, AM_IMM, RG_A};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_clock_divider.sv
// Tick generator: counts 0..CLOCK_DIVIDER-1 and registers a one-clock tick on
// wrap. With CLOCK_DIVIDER=1 the tick stays high every clock.
module cpu_clock_divider #(
  parameter int CLOCK_DIVIDER = 12
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick
);

  logic [7:0] cnt_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= 8'd0;
      tick  <= 1'b0;
    end else if (cnt_q == 8'(CLOCK_DIVIDER - 1)) begin
      cnt_q <= 8'd0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_core.sv
// Tick-divided 6502-style core: loads/stores of A/X/Y in imm/zp/zp-indexed/abs
// modes over a stall-on-invalid bus. Define CPU_TRACE_EN for debug trace ports.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int          CLOCK_DIVIDER = 12,
  parameter logic [15:0] RESET_VECTOR  = 16'hFFFC
) (
  input  logic        clock_i,
  input  logic        reset_i,
`ifdef CPU_TRACE_EN
  output logic        tick_o,
  output logic        sync_o,
  output logic [15:0] program_counter_o,
  output logic [7:0]  accumulator_o,
  output logic [7:0]  index_x_o,
  output logic [7:0]  index_y_o,
  output logic [7:0]  status_o,
  output logic [7:0]  stack_pointer_o,
  output logic [7:0]  instruction_o,
`endif
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  output logic [7:0]  data_o,
  output logic [15:0] address_o,
  output logic        address_valid_o,
  output logic        data_valid_o
);

  logic        tick;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d;
  logic [7:0]  ir_q, ir_d, lo_q, lo_d;
  logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        load_en;
  decode_t     dec;
  logic [7:0]  store_val, index_val, zp_idx;

  cpu_clock_divider #(.CLOCK_DIVIDER(CLOCK_DIVIDER)) u_div (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .tick    (tick)
  );

  assign dec       = decode(ir_q);
  assign index_val = (dec.rsel == RG_X) ? y_q : x_q;
  assign zp_idx    = lo_q + index_val;

  always_comb begin
    case (dec.rsel)
      RG_X:    store_val = x_q;
      RG_Y:    store_val = y_q;
      default: store_val = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    lo_d    = lo_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    load_en = 1'b0;
    // Read states advance only with valid data; ACCESS stores never wait.
    if (tick) begin
      case (state_q)
        ST_RESET_LO: if (data_valid_i) begin
          pc_d    = {pc_q[15:8], data_i};
          addr_d  = RESET_VECTOR + 16'd1;
          state_d = ST_RESET_HI;
        end
        ST_RESET_HI: if (data_valid_i) begin
          pc_d    = {data_i, pc_q[7:0]};
          addr_d  = {data_i, pc_q[7:0]};
          state_d = ST_FETCH;
        end
        ST_FETCH: if (data_valid_i) begin
          ir_d    = data_i;
          pc_d    = pc_q + 16'd1;
          addr_d  = pc_q + 16'd1;
          state_d = ST_OPERAND_LO;
        end
        ST_OPERAND_LO: if (data_valid_i) begin
          lo_d = data_i;
          if (dec.kind == K_NOP) begin
            state_d = ST_FETCH;
          end else begin
            pc_d = pc_q + 16'd1;
            case (dec.mode)
              AM_IMM: begin
                load_en = 1'b1;
                addr_d  = pc_q + 16'd1;
                state_d = ST_FETCH;
              end
              AM_ZP: begin
                addr_d  = {8'h00, data_i};
                state_d = ST_ACCESS;
                if (dec.kind == K_STORE) begin
                  wr_d   = 1'b1;
                  dout_d = store_val;
                end
              end
              AM_ZPI: begin
                addr_d  = {8'h00, data_i};
                state_d = ST_INDEX;
              end
              default: begin
                addr_d  = pc_q + 16'd1;
                state_d = ST_OPERAND_HI;
              end
            endcase
          end
        end
        ST_OPERAND_HI: if (data_valid_i) begin
          pc_d    = pc_q + 16'd1;
          addr_d  = {data_i, lo_q};
          state_d = ST_ACCESS;
          if (dec.kind == K_STORE) begin
            wr_d   = 1'b1;
            dout_d = store_val;
          end
        end
        ST_INDEX: begin
          addr_d  = {8'h00, zp_idx};
          state_d = ST_ACCESS;
          if (dec.kind == K_STORE) begin
            wr_d   = 1'b1;
            dout_d = store_val;
          end
        end
        ST_ACCESS: begin
          if (dec.kind == K_STORE) begin
            wr_d    = 1'b0;
            addr_d  = pc_q;
            state_d = ST_FETCH;
          end else if (data_valid_i) begin
            load_en = 1'b1;
            addr_d  = pc_q;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_RESET_LO;
      endcase
    end
    if (load_en) begin
      case (dec.rsel)
        RG_X:    x_d = data_i;
        RG_Y:    y_d = data_i;
        default: a_d = data_i;
      endcase
      p_d[STATUS_ZERO]     = (data_i == 8'h00);
      p_d[STATUS_NEGATIVE] = data_i[7];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_RESET_LO;
      pc_q    <= 16'h0000;
      addr_q  <= RESET_VECTOR;
      ir_q    <= 8'h00;
      lo_q    <= 8'h00;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      p_q     <= P_RESET;
      dout_q  <= 8'h00;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
    end
  end

  assign address_o       = addr_q;
  assign address_valid_o = 1'b1;
  assign data_o          = dout_q;
  assign data_valid_o    = wr_q;

`ifdef CPU_TRACE_EN
  logic [7:0] sp_q;

  // No stack instructions yet, so SP only ever holds its reset value.
  always_ff @(posedge clock_i) begin
    if (reset_i) sp_q <= SP_RESET;
  end

  assign tick_o            = tick;
  assign sync_o            = (state_q == ST_FETCH);
  assign program_counter_o = pc_q;
  assign accumulator_o     = a_q;
  assign index_x_o         = x_q;
  assign index_y_o         = y_q;
  assign status_o          = p_q;
  assign stack_pointer_o   = sp_q;
  assign instruction_o     = ir_q;
`else
  // Trace ports absent; the core carries no extra state.
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: an instruction-level model expands each opcode into its
// expected bus cycles; the compare process checks the bus every clock.
module tb_cpu_core;

  localparam int CD = 2;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        data_valid_i = 1'b1;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic [15:0] address_o;
  logic        address_valid_o;
  logic        data_valid_o;

  logic [7:0]  mem [0:65535];
  assign data_i = mem[address_o];

  always #5 clock_i = ~clock_i;

  cpu_core #(.CLOCK_DIVIDER(CD), .RESET_VECTOR(16'hFFFC)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .data_i          (data_i),
    .data_valid_i    (data_valid_i),
    .data_o          (data_o),
    .address_o       (address_o),
    .address_valid_o (address_valid_o),
    .data_valid_o    (data_valid_o)
  );

  typedef struct {
    logic [15:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        dc;
  } bus_t;

  bus_t        bus_q[$];
  logic [15:0] alog[$];
  logic [23:0] wlog[$];
  logic [15:0] mpc;
  logic [7:0]  ma, mx, my;
  int          n_chk = 0, n_pass = 0, cyc = 0, stalls_left = 3;
  logic        hit = 1'b0, hit2 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic push(input logic [15:0] a, input logic wr, input logic [7:0] d, input logic dc);
    bus_t b;
    b.a = a; b.wr = wr; b.d = d; b.dc = dc;
    bus_q.push_back(b);
  endtask

  // Register selected by opcode bits [1:0]: 01 -> A, 10 -> X, 00 -> Y.
  function automatic logic [7:0] getreg(input logic [7:0] op);
    case (op[1:0])
      2'b01:   return ma;
      2'b10:   return mx;
      default: return my;
    endcase
  endfunction

  task automatic setreg(input logic [7:0] op, input logic [7:0] v);
    case (op[1:0])
      2'b01:   ma = v;
      2'b10:   mx = v;
      default: my = v;
    endcase
  endtask

  task automatic model_step();
    logic [7:0]  op, o1, o2, idx;
    logic [15:0] p1, p2, ea;
    p1 = mpc + 16'd1;
    p2 = mpc + 16'd2;
    op = mem[mpc]; o1 = mem[p1]; o2 = mem[p2];
    idx = (op == 8'hB6 || op == 8'h96) ? my : mx;
    push(mpc, 1'b0, 8'h00, 1'b0);
    case (op)
      8'hA9, 8'hA2, 8'hA0: begin
        push(p1, 1'b0, 8'h00, 1'b0); setreg(op, o1); mpc = p2;
      end
      8'hA5, 8'hA6, 8'hA4: begin
        ea = {8'h00, o1};
        push(p1, 1'b0, 8'h00, 1'b0); push(ea, 1'b0, 8'h00, 1'b0);
        setreg(op, mem[ea]); mpc = p2;
      end
      8'hB5, 8'hB6, 8'hB4: begin
        ea = {8'h00, 8'(o1 + idx)};
        push(p1, 1'b0, 8'h00, 1'b0); push(16'h0000, 1'b0, 8'h00, 1'b1);
        push(ea, 1'b0, 8'h00, 1'b0); setreg(op, mem[ea]); mpc = p2;
      end
      8'hAD, 8'hAE, 8'hAC: begin
        ea = {o2, o1};
        push(p1, 1'b0, 8'h00, 1'b0); push(p2, 1'b0, 8'h00, 1'b0);
        push(ea, 1'b0, 8'h00, 1'b0); setreg(op, mem[ea]); mpc = mpc + 16'd3;
      end
      8'h85, 8'h86, 8'h84: begin
        push(p1, 1'b0, 8'h00, 1'b0); push({8'h00, o1}, 1'b1, getreg(op), 1'b0); mpc = p2;
      end
      8'h95, 8'h96, 8'h94: begin
        ea = {8'h00, 8'(o1 + idx)};
        push(p1, 1'b0, 8'h00, 1'b0); push(16'h0000, 1'b0, 8'h00, 1'b1);
        push(ea, 1'b1, getreg(op), 1'b0); mpc = p2;
      end
      8'h8D, 8'h8E, 8'h8C: begin
        push(p1, 1'b0, 8'h00, 1'b0); push(p2, 1'b0, 8'h00, 1'b0);
        push({o2, o1}, 1'b1, getreg(op), 1'b0); mpc = mpc + 16'd3;
      end
      default: begin
        push(p1, 1'b0, 8'h00, 1'b1); mpc = p1;
      end
    endcase
  endtask

  // Compare process: consumes one expected bus cycle per unstalled tick.
  initial begin : cmp
    bus_t h;
    logic rs, dvs, te;
    forever begin
      @(posedge clock_i);
      rs  = reset_i;
      dvs = data_valid_i;
      if (rs) begin
        cyc = 0;
        bus_q.delete();
        alog.delete();
        ma = 8'h00; mx = 8'h00; my = 8'h00;
        mpc = {mem[16'hFFFD], mem[16'hFFFC]};
        push(16'hFFFC, 1'b0, 8'h00, 1'b0);
        push(16'hFFFD, 1'b0, 8'h00, 1'b0);
        #1;
        chk("reset_address", address_o, 16'hFFFC);
        chk("reset_write_strobe", data_valid_o, 1'b0);
        chk("reset_data", data_o, 8'h00);
        chk("reset_address_valid", address_valid_o, 1'b1);
      end else begin
        cyc++;
        te = (cyc >= CD + 1) && ((cyc - 1) % CD == 0);
        if (te && bus_q.size() > 0 && !(!dvs && !bus_q[0].wr)) void'(bus_q.pop_front());
        #1;
        if (bus_q.size() == 0) model_step();
        h = bus_q[0];
        if (h.dc) begin
          chk("internal_cycle_no_write", data_valid_o, 1'b0);
        end else begin
          chk("bus_address", address_o, h.a);
          chk("bus_write_strobe", data_valid_o, h.wr);
          if (h.wr) chk("bus_write_data", data_o, h.d);
        end
        chk("address_valid", address_valid_o, 1'b1);
        if (te || cyc == 1) begin
          alog.push_back(address_o);
          if (data_valid_o) wlog.push_back({address_o, data_o});
          if (h.wr && h.a == 16'h0500) hit = 1'b1;
          if (h.wr && h.a == 16'h0050) hit2 = 1'b1;
          if (h.a == 16'h800F && !h.wr && stalls_left > 0) begin
            data_valid_i = 1'b0;
            stalls_left--;
          end else begin
            data_valid_i = 1'b1;
          end
        end
      end
    end
  end

  function automatic int count_addr(input logic [15:0] a);
    int n = 0;
    foreach (alog[i]) if (alog[i] == a) n++;
    return n;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] prog [0:32];
    int waited;
    logic [23:0] exp_w [0:6];
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    prog = '{8'hA2, 8'h05, 8'hB5, 8'h10, 8'hB4, 8'hFF, 8'h96, 8'hF0,
             8'hA9, 8'hAA, 8'h8D, 8'h34, 8'h12, 8'hAD, 8'h00, 8'h30,
             8'h85, 8'h40, 8'hA6, 8'h15, 8'h8E, 8'h00, 8'h02, 8'h84,
             8'h41, 8'h94, 8'h42, 8'hA0, 8'h33, 8'hEA, 8'h8D, 8'h00, 8'h05};
    for (int i = 0; i < 33; i++) mem[16'h8000 + i] = prog[i];
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'hFFFF] = 8'h02;
    mem[16'h0015] = 8'h80; mem[16'h0004] = 8'h20; mem[16'h3000] = 8'h5A;
    mem[16'h0000] = 8'h85; mem[16'h0001] = 8'h50;
    exp_w = '{24'h001005, 24'h1234AA, 24'h00405A, 24'h020080,
              24'h004120, 24'h00C220, 24'h05005A};

    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;

    waited = 0;
    while (!hit && waited < 3000) begin
      @(posedge clock_i); #2; waited++;
    end
    chk("reached_sta_0500", hit, 1'b1);
    chk("first_fetch_8000", (alog.size() > 2) ? alog[2] : 16'hDEAD, 16'h8000);
    chk("zp_wrap_read_0004", count_addr(16'h0004), 1);
    chk("stall_holds_800F_4_periods", count_addr(16'h800F), 4);
    chk("store_1234_once", count_addr(16'h1234), 1);
    chk("model_a", ma, 8'h5A);
    chk("model_x", mx, 8'h80);
    chk("model_y", my, 8'h33);
    chk("write_count", wlog.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < wlog.size()) chk($sformatf("write_%0d", i), wlog[i], exp_w[i]);

    // Reset lands during the STA $0500 strobe; new vector boots at FFFF.
    mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF;
    reset_i = 1'b1;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;

    waited = 0;
    while (!hit2 && waited < 3000) begin
      @(posedge clock_i); #2; waited++;
    end
    chk("reached_sta_0050", hit2, 1'b1);
    chk("reboot_vector_fetch_FFFF", (alog.size() > 2) ? alog[2] : 16'hDEAD, 16'hFFFF);
    chk("pc_wrap_fetch_0000", (alog.size() > 4) ? alog[4] : 16'hDEAD, 16'h0000);
    chk("write_count_after_reboot", wlog.size(), 8);
    if (wlog.size() > 7) chk("post_reset_sta_a_zero", wlog[7], 24'h005000);
    repeat (6) @(posedge clock_i);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised successor to the first-generation 6502-style `cpu`: same tick-divided memory bus with a stall-on-invalid read handshake, extended with stores (`data_valid_o` write strobe), absolute and zero-page-indexed addressing for all three registers, and a configurable reset vector. It sits between the system bus arbiter and memory/PPU/APU decode. All architectural state advances only on divider ticks.

## Interface
- `CLOCK_DIVIDER`, 12: system clocks per CPU tick; legal range 1..255.
- `RESET_VECTOR`, 16'hFFFC: address of the reset-vector low byte; the high byte is read at `RESET_VECTOR+1`.
- `clock_i` in 1: system clock; the only clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `data_i` in 8: read data, sampled on a tick.
- `data_valid_i` in 1: `data_i` valid on this tick; low on any read tick stalls the core.
- `data_o` out 8: write data; meaningful only while `data_valid_o` is high.
- `address_o` out 16: bus address.
- `address_valid_o` out 1: `address_o` valid.
- `data_valid_o` out 1: write strobe; high for exactly one tick period per store.

## Operation
- Tick: divider counts 0..CLOCK_DIVIDER-1 and registers `tick` high for one clock on wrap. First tick is CLOCK_DIVIDER+1 clocks after reset release.
- Reset values: `address_o`=RESET_VECTOR, `address_valid_o`=1, `data_valid_o`=0, `data_o`=0; A/X/Y=0, SP=8'hFD, P=8'h34, divider=0, state=RESET_LO.
- States: RESET_LO → RESET_HI → FETCH → OPERAND_LO → [OPERAND_HI | INDEX] → ACCESS → FETCH.
  - RESET_LO: latch PCL, drive RESET_VECTOR+1.
  - RESET_HI: latch PCH, drive the new PC.
  - FETCH: latch the opcode, drive PC+1.
- Opcodes:
  - Loads: LDA A9/A5/B5/AD; LDX A2/A6/B6/AE; LDY A0/A4/B4/AC.
  - Stores: STA 85/95/8D; STX 86/96/8E; STY 84/94/8C.
  - NOP EA.
- Tick counts per instruction: imm 2, zp 3, zp-indexed 4, abs 4, for both loads and stores. NOP takes 2.
- Any undefined opcode executes as a 2-tick NOP: no register or flag change, and PC advances by 1.
- Loads update Z (bit 1) and N (bit 7) from the loaded byte. Stores and NOP leave P unchanged.
- Arithmetic:
  - PC increment is 16-bit and wraps FFFF→0000.
  - Zero-page indexed address is `{8'h00, (operand+index)[7:0]}`; it wraps within page zero, with no carry into the high byte.
  - LDX/STX indexed use Y; every other indexed form uses X.
  - Absolute address is `{hi, lo}` in operand order.
- Stall: on a read tick with `data_valid_i`=0, state, registers and bus outputs hold, and the same read retries on the next tick. Write ticks never stall.
- Store ACCESS tick: drive `address_o`, `data_o` and `data_valid_o`=1. On the following tick `data_valid_o` returns to 0 and the PC fetch is driven.
- Reset mid-instruction: the instruction is abandoned, and `data_valid_o` drops on the reset clock edge. A store already strobed is not retracted.

## Timing
- Outputs change only on clock edges where `tick`=1, and are registered (no combinational path from `data_i` to outputs).
- Memory sees each address for a full tick period. Read data is due by the next tick.
- An instruction's last tick presents the next opcode address, so back-to-back instructions have zero bubble.
- With CLOCK_DIVIDER=1, `tick` stays high every clock after the first and the core runs at full clock rate.

## Configuration
- `CPU_TRACE_EN` defined: adds outputs `tick_o`, `sync_o`, `program_counter_o`[16], `accumulator_o`, `index_x_o`, `index_y_o`, `status_o`, `stack_pointer_o`, `instruction_o` (all 8 bits unless stated).
  - `sync_o` is high while the FETCH state is waiting on a tick.
- `CPU_TRACE_EN` undefined: these ports and their logic are absent, and functional behaviour is identical.

## Structure
- `cpu_pkg`: opcode localparams, state enum, status bit indices (STATUS_ZERO=1, STATUS_NEGATIVE=7), P reset value.
- Sub-module `cpu_clock_divider` (CLOCK_DIVIDER parameter; clock/reset in, `tick` out).
- Decode, address generation and register update live in `cpu_core`.

## Test plan
- Reset boot, CLOCK_DIVIDER=2, memory FFFC=00 FFFD=80 → first opcode fetch at 8000; A=X=Y=0, P=34.
- Load modes: LDX #05; LDA $10,X with 15=80 → A=80, N=1, Z=0. LDY $FF,X with X=05 → reads 0004, proving page-zero wrap.
- Stores: STA $1234 with A=AA → exactly one tick with address 1234, `data_o`=AA, `data_valid_o`=1, P unchanged. STX $F0,Y with Y=20 → write to 0010.
- Stall: hold `data_valid_i`=0 for 3 ticks during LDA abs operand-high → address and state frozen. The instruction completes 3 ticks late with the correct A.
- PC wrap and illegal opcode: opcode 02 at FFFF → 2-tick NOP, next fetch at 0000, registers unchanged.
- Reset asserted on the STA ACCESS tick → `data_valid_o`=0 next clock, `address_o`=RESET_VECTOR, boot sequence restarts.
